// File: rtl/adc_snapshot_streamer_if.sv
// Stream bundle between the capture front end, the snapshot streamer and the
// downstream consumer.
//
// Handshake: a word moves across a channel on a rising clock edge when
// valid && ready are both high in the cycle before that edge. A producer that
// has raised valid keeps valid and its data/last stable until the transfer
// happens. ready may depend combinationally on valid and on state.
// s_* is the input channel into the streamer, m_* is its output channel.
interface adc_snapshot_streamer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  // Environment side: drives input words and downstream accept.
  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  // Streamer side.
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/adc_snapshot_streamer.sv
// ADC snapshot streamer: arms on request, starts capturing on a trigger while
// the front end is aligned, decimates accepted words and forwards them through
// a single output register. Snapshot mode stops after snap_len words and tags
// the final one with m_last; continuous mode runs until enable drops.
module adc_snapshot_streamer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int DEC_W  = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 arm,
  input  logic                 trigger,
  input  logic [CNT_W-1:0]     snap_len,
  input  logic [DEC_W-1:0]     decim,
  input  logic                 aligned,
  adc_snapshot_streamer_if.slave bus,
  output logic [1:0]           state,
  output logic                 snapshot_done,
  output logic [CNT_W-1:0]     word_count,
  output logic [15:0]          drop_count,
  output logic                 align_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  snap_len_q;
  logic [DEC_W-1:0]  decim_q;
  logic [DEC_W-1:0]  dec_cnt_q;
  logic [DEC_W-1:0]  dec_top;
  logic [CNT_W-1:0]  word_count_q;
  logic [CNT_W-1:0]  wc_next;
  logic [15:0]       drop_count_q;
  logic              align_err_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;
  logic              m_last_q;

  logic in_capture;
  logic s_ready_c;
  logic accept;
  logic cap_accept;
  logic fwd;
  logic fwd_last;
  logic arm_take;

  // Handshake and datapath decode for the current cycle.
  always_comb begin
    in_capture = (state_q == CAPTURE);
    // Outside CAPTURE the input is always drained (and discarded); inside it
    // the single output register must be free or emptying this cycle.
    s_ready_c  = in_capture ? (aligned && (!m_valid_q || bus.m_ready)) : 1'b1;
    accept     = bus.s_valid && s_ready_c;
    cap_accept = in_capture && accept;
    // decim of 0 or 1 both mean keep every word.
    dec_top    = (decim_q <= DEC_W'(1)) ? '0 : (decim_q - DEC_W'(1));
    fwd        = cap_accept && (dec_cnt_q == '0);
    wc_next    = word_count_q + CNT_W'(1);
    fwd_last   = !mode && (wc_next == snap_len_q);
    arm_take   = enable && arm && ((state_q == IDLE) || (state_q == DONE));
  end

  // Next-state selection, enable has top priority.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED: begin
          if (trigger && aligned) begin
            // A zero-length snapshot completes immediately with no words.
            state_d = (!mode && (snap_len_q == '0)) ? DONE : CAPTURE;
          end
        end
        CAPTURE: if (fwd && fwd_last) state_d = DONE;
        DONE:    if (arm) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Arm-time latches, counters and the sticky alignment error.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      snap_len_q   <= '0;
      decim_q      <= '0;
      dec_cnt_q    <= '0;
      word_count_q <= '0;
      drop_count_q <= '0;
      align_err_q  <= 1'b0;
    end else if (arm_take) begin
      snap_len_q   <= snap_len;
      decim_q      <= decim;
      dec_cnt_q    <= '0;
      word_count_q <= '0;
      drop_count_q <= '0;
      align_err_q  <= 1'b0;
    end else begin
      if (cap_accept) begin
        dec_cnt_q <= (dec_cnt_q == dec_top) ? '0 : (dec_cnt_q + DEC_W'(1));
      end
      if (fwd && (word_count_q != '1)) begin
        word_count_q <= wc_next;
      end
      if ((state_q == ARMED) && accept && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
      if (in_capture && !aligned) begin
        align_err_q <= 1'b1;
      end
    end
  end

  // Single output register; a loaded word holds until the consumer takes it,
  // independent of state or enable.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (fwd) begin
      m_data_q  <= bus.s_data;
      m_valid_q <= 1'b1;
      m_last_q  <= fwd_last;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign state          = state_q;
  assign snapshot_done  = (state_q == DONE);
  assign word_count     = word_count_q;
  assign drop_count     = drop_count_q;
  assign align_err      = align_err_q;

endmodule

// File: tb/tb_adc_snapshot_streamer.sv
// Bench for adc_snapshot_streamer: reset checks, a table of ramp snapshots,
// hand-written corner sequences and randomized runs scored against a model
// that filters the accepted input stream by decimation and snapshot length.
module tb_adc_snapshot_streamer;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 32;
  localparam int DEC_W  = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              enable, mode, arm, trigger, aligned;
  logic [CNT_W-1:0]  snap_len;
  logic [DEC_W-1:0]  decim;
  logic [1:0]        state;
  logic              snapshot_done;
  logic [CNT_W-1:0]  word_count;
  logic [15:0]       drop_count;
  logic              align_err;

  adc_snapshot_streamer_if #(.DATA_W(DATA_W)) bus ();

  adc_snapshot_streamer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEC_W(DEC_W)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .enable        (enable),
    .mode          (mode),
    .arm           (arm),
    .trigger       (trigger),
    .snap_len      (snap_len),
    .decim         (decim),
    .aligned       (aligned),
    .bus           (bus),
    .state         (state),
    .snapshot_done (snapshot_done),
    .word_count    (word_count),
    .drop_count    (drop_count),
    .align_err     (align_err)
  );

  // Clock and watchdog.
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] acc_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              got_last_q[$];

  bit                rec_en;
  bit                ramp_en;
  logic [DATA_W-1:0] ramp;
  int                hold_err;
  int                stall_err;
  bit                prev_hold;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  typedef struct {
    int                len;
    int                dec;
    int                exp_n;
    logic [DATA_W-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge.
  task automatic cycle();
    bit acc;
    @(negedge sys_clk);
    acc = bus.s_valid && bus.s_ready;
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(bus.m_data);
      got_last_q.push_back(bus.m_last);
    end
    if (rec_en && acc) acc_q.push_back(bus.s_data);
    if (prev_hold && (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last))
      hold_err++;
    prev_hold = bus.m_valid && !bus.m_ready;
    prev_data = bus.m_data;
    prev_last = bus.m_last;
    if (state == 2'd2 && bus.s_ready !== (aligned && (!bus.m_valid || bus.m_ready)))
      stall_err++;
    @(posedge sys_clk);
    #1;
    if (ramp_en && acc) begin
      ramp++;
      bus.s_data = ramp;
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    acc_q.delete();
    got_q.delete();
    got_last_q.delete();
  endtask

  // Arm with the given settings, trigger, then start offering a ramp.
  task automatic begin_snapshot(input int len, input int dec, input bit md);
    clear_queues();
    mode        = md;
    aligned     = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    ramp        = '0;
    bus.s_data  = '0;
    snap_len    = CNT_W'(len);
    decim       = DEC_W'(dec);
    arm = 1'b1;     cycle(); arm = 1'b0;
    trigger = 1'b1; cycle(); trigger = 1'b0;
    rec_en      = 1'b1;
    ramp_en     = 1'b1;
    bus.s_valid = 1'b1;
  endtask

  task automatic finish_run(input string tag);
    check({tag, " reached DONE"}, state, 2'd3);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    aligned     = 1'b1;
    repeat (3) cycle();
    rec_en  = 1'b0;
    ramp_en = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while (state != 2'd3 && n < budget) begin
      cycle();
      n++;
    end
    finish_run(tag);
  endtask

  // Reference: every k-th captured accept is forwarded, at most len of them
  // in snapshot mode, and only the final snapshot word is tagged last.
  task automatic score(input string tag, input int len, input int dec, input bit snap);
    int k;
    int nlast;
    int n;
    k = (dec < 2) ? 1 : dec;
    exp_q.delete();
    for (int i = 0; i < acc_q.size(); i += k)
      if (!snap || exp_q.size() < len) exp_q.push_back(acc_q[i]);
    check({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    nlast = 0;
    foreach (got_last_q[i]) if (got_last_q[i]) nlast++;
    check({tag, " last count"}, 64'(nlast), (snap && len > 0) ? 64'd1 : 64'd0);
    if (snap && len > 0 && got_last_q.size() > 0)
      check({tag, " last on final"}, 64'(got_last_q[got_last_q.size()-1]), 64'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    int bad;
    int len;
    int dec;
    int n;

    vecs[0] = '{len: 4, dec: 1, exp_n: 4, exp_last: 16'd3};
    vecs[1] = '{len: 3, dec: 3, exp_n: 3, exp_last: 16'd6};
    vecs[2] = '{len: 2, dec: 0, exp_n: 2, exp_last: 16'd1};
    vecs[3] = '{len: 5, dec: 2, exp_n: 5, exp_last: 16'd8};
    vecs[4] = '{len: 0, dec: 1, exp_n: 0, exp_last: 16'd0};

    enable = 1'b1; mode = 1'b0; arm = 1'b0; trigger = 1'b0; aligned = 1'b1;
    snap_len = '0; decim = DEC_W'(1);
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    rec_en = 1'b0; ramp_en = 1'b0; ramp = '0;
    hold_err = 0; stall_err = 0; prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;

    // Reset state.
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset state", state, 2'd0);
    check("reset s_ready", bus.s_ready, 1'b1);
    check("reset m_valid", bus.m_valid, 1'b0);
    check("reset m_last", bus.m_last, 1'b0);
    check("reset m_data", bus.m_data, 16'd0);
    check("reset word_count", word_count, 32'd0);
    check("reset drop_count", drop_count, 16'd0);
    check("reset align_err", align_err, 1'b0);
    check("reset snapshot_done", snapshot_done, 1'b0);
    sys_rst = 1'b0;
    cycle();

    // Table of ramp snapshots with a free-running consumer.
    foreach (vecs[v]) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      begin_snapshot(vecs[v].len, vecs[v].dec, 1'b0);
      run_until_done(tag, 200);
      check({tag, " word_count"}, word_count, 64'(vecs[v].exp_n));
      check({tag, " snapshot_done"}, snapshot_done, 1'b1);
      check({tag, " outputs"}, 64'(got_q.size()), 64'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0)
        check({tag, " final data"}, (got_q.size() > 0) ? 64'(got_q[got_q.size()-1]) : 64'hDEAD,
              64'(vecs[v].exp_last));
      score(tag, vecs[v].len, vecs[v].dec, 1'b1);
    end

    // Consumer stall for 5 cycles mid-snapshot.
    begin_snapshot(8, 1, 1'b0);
    repeat (3) cycle();
    bus.m_ready = 1'b0;
    #1;
    held = bus.m_data;
    check("stall m_valid", bus.m_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.s_ready !== 1'b0) bad++;
      cycle();
      if (bus.m_data !== held || bus.m_valid !== 1'b1) bad++;
    end
    check("stall hold", 64'(bad), 64'd0);
    bus.m_ready = 1'b1;
    run_until_done("stall", 200);
    for (int i = 0; i < 8; i++)
      check($sformatf("stall ramp%0d", i), (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'(i));
    score("stall", 8, 1, 1'b1);

    // Words in ARMED are dropped; misaligned trigger and arm+trigger in IDLE.
    clear_queues();
    mode = 1'b0; snap_len = CNT_W'(2); decim = DEC_W'(1);
    arm = 1'b1; cycle(); arm = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 16'h00AA;
    repeat (5) cycle();
    bus.s_valid = 1'b0;
    cycle();
    check("armed drop_count", drop_count, 16'd5);
    check("armed no output", 64'(got_q.size()), 64'd0);
    aligned = 1'b0; trigger = 1'b1; cycle(); trigger = 1'b0; aligned = 1'b1;
    check("misaligned trigger ignored", state, 2'd1);
    enable = 1'b0; cycle(); enable = 1'b1;
    check("enable low to IDLE", state, 2'd0);
    arm = 1'b1; trigger = 1'b1; cycle(); arm = 1'b0; trigger = 1'b0;
    check("arm+trigger in IDLE", state, 2'd1);
    enable = 1'b0; cycle(); enable = 1'b1;

    // Alignment loss for 3 cycles during capture.
    begin_snapshot(6, 1, 1'b0);
    repeat (2) cycle();
    aligned = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.s_ready !== 1'b0) bad++;
      cycle();
    end
    aligned = 1'b1;
    check("align stall", 64'(bad), 64'd0);
    check("align_err set", align_err, 1'b1);
    check("align state", state, 2'd2);
    run_until_done("align", 200);
    check("align word_count", word_count, 32'd6);
    check("align_err sticky", align_err, 1'b1);
    score("align", 6, 1, 1'b1);

    // Continuous mode, enable drops while a word is pending.
    begin_snapshot(3, 1, 1'b1);
    repeat (6) cycle();
    check("cont still capturing", state, 2'd2);
    bus.m_ready = 1'b0;
    cycle();
    bus.s_valid = 1'b0;
    enable = 1'b0;
    cycle();
    check("cont idle", state, 2'd0);
    check("cont pending held", bus.m_valid, 1'b1);
    bus.m_ready = 1'b1;
    cycle();
    check("cont pending delivered", bus.m_valid, 1'b0);
    rec_en = 1'b0; ramp_en = 1'b0;
    repeat (2) cycle();
    check("cont word_count", word_count, 64'(got_q.size()));
    score("cont", 0, 1, 1'b0);
    enable = 1'b1;

    // Reset mid-capture with a pending output word.
    begin_snapshot(10, 1, 1'b0);
    repeat (3) cycle();
    bus.m_ready = 1'b0;
    cycle();
    #2;
    sys_rst = 1'b1;
    #1;
    check("midrst m_valid", bus.m_valid, 1'b0);
    check("midrst state", state, 2'd0);
    check("midrst s_ready", bus.s_ready, 1'b1);
    check("midrst m_data", bus.m_data, 16'd0);
    check("midrst word_count", word_count, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    prev_hold = 1'b0;
    bus.s_valid = 1'b0; bus.m_ready = 1'b1; rec_en = 1'b0; ramp_en = 1'b0;
    cycle();
    check("after reset idle", state, 2'd0);

    // Randomized snapshots.
    for (int r = 0; r < 6; r++) begin
      string tag;
      tag = $sformatf("rand%0d", r);
      len = $urandom_range(1, 12);
      dec = $urandom_range(0, 4);
      clear_queues();
      mode = 1'b0; snap_len = CNT_W'(len); decim = DEC_W'(dec);
      aligned = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      arm = 1'b1;     cycle(); arm = 1'b0;
      trigger = 1'b1; cycle(); trigger = 1'b0;
      rec_en = 1'b1;
      n = 0;
      while (state != 2'd3 && n < 600) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = DATA_W'($urandom);
        bus.m_ready = ($urandom_range(0, 9) < 7);
        aligned     = ($urandom_range(0, 9) != 0);
        cycle();
        n++;
      end
      finish_run(tag);
      check({tag, " word_count"}, word_count, 64'(len));
      score(tag, len, dec, 1'b1);
    end

    // Randomized continuous runs.
    for (int r = 0; r < 2; r++) begin
      string tag;
      tag = $sformatf("rcont%0d", r);
      dec = $urandom_range(0, 3);
      clear_queues();
      mode = 1'b1; snap_len = CNT_W'(4); decim = DEC_W'(dec);
      aligned = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      arm = 1'b1;     cycle(); arm = 1'b0;
      trigger = 1'b1; cycle(); trigger = 1'b0;
      rec_en = 1'b1;
      for (int c = 0; c < 80; c++) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = DATA_W'($urandom);
        bus.m_ready = ($urandom_range(0, 9) < 7);
        aligned     = ($urandom_range(0, 9) != 0);
        cycle();
      end
      bus.s_valid = 1'b0; bus.m_ready = 1'b1; aligned = 1'b1;
      repeat (3) cycle();
      check({tag, " still capturing"}, state, 2'd2);
      enable = 1'b0; cycle(); enable = 1'b1;
      rec_en = 1'b0;
      check({tag, " word_count"}, word_count, 64'(got_q.size()));
      score(tag, 0, dec, 1'b0);
      mode = 1'b0;
    end

    check("output hold violations", 64'(hold_err), 64'd0);
    check("capture ready violations", 64'(stall_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
